hub75_scan_ctrl: RTL and testbench

- Scan scheduler for the HUB75 panel chain; sits directly above hub75_fetchshift.
- Walks row address × bit-plane order: kicks a shift, waits for it, blanks, latches, then enables output for a binary-weighted on-time.
- The shift of the next plane overlaps the on-time of the current plane.
- Drives panel address, LAT and OE_n pins, plus the start/bit/row inputs of the shifter.

---
 rtl/hub75_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan scheduler: walks row x bit-plane, kicks the shifter, then blanks,
// latches and runs a binary-weighted OE on-time that overlaps the next shift.
//   state   | meaning
//   S_IDLE  | stopped; the last on-time may still be counting out
//   S_KICK  | one-cycle start pulse to the shifter
//   S_WAIT  | wait for shift done and on-timer expiry
//   S_BLANK | OE off, address settling
//   S_LATCH | LAT pulse
//   S_SWAP  | load on-timer, advance the (row,bit) pointer
module hub75_scan_ctrl #(
    parameter int ROWS      = 32,
    parameter int BITS      = 8,
    parameter int BASE_OE   = 16,
    parameter int BLANK_CYC = 2,
    parameter int TIMER_W   = 16
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_fs_busy,
    output logic       o_fs_start,
    output logic [2:0] o_fs_bit_cnt,
    output logic [5:0] o_fs_row_cnt,
    output logic [5:0] o_addr,
    output logic       o_lat,
    output logic       o_oe_n,
    output logic       o_frame_done
);

    localparam int BLANK_W = $clog2(BLANK_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_BLANK,
        S_LATCH,
        S_SWAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [5:0]           r_ptr_row;
    logic [2:0]           r_ptr_bit;
    logic [5:0]           w_ptr_row_nxt;
    logic [2:0]           w_ptr_bit_nxt;
    logic                 r_wait_first;
    logic [BLANK_W-1:0]   r_blank_cnt;
    logic                 r_fs_start;
    logic [2:0]           r_fs_bit_cnt;
    logic [5:0]           r_fs_row_cnt;
    logic [5:0]           r_addr;
    logic                 r_lat;
    logic                 r_oe_n;
    logic                 r_frame_done;
    logic                 w_last_bit;
    logic                 w_last_row;
    logic                 w_wrap;
    logic                 w_timer_zero;

    assign w_last_bit   = (r_ptr_bit == 3'(BITS - 1));
    assign w_last_row   = (r_ptr_row == 6'(ROWS - 1));
    assign w_wrap       = w_last_bit && w_last_row;
    assign w_timer_zero = (r_timer == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_enable) w_state_nxt = S_KICK;
            S_KICK:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Busy from the shifter lags the start pulse by a cycle
                if (!r_wait_first && !i_fs_busy && w_timer_zero)
                    w_state_nxt = S_BLANK;
            end
            S_BLANK: if (r_blank_cnt == '0) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_SWAP;
            S_SWAP: begin
                if (w_wrap && !i_enable) w_state_nxt = S_IDLE;
                else                     w_state_nxt = S_KICK;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_timer_nxt = r_timer;
        if (r_state == S_SWAP)
            w_timer_nxt = TIMER_W'(BASE_OE) << r_fs_bit_cnt;
        else if (!w_timer_zero)
            w_timer_nxt = r_timer - TIMER_W'(1);
    end

    always_comb begin
        w_ptr_row_nxt = r_ptr_row;
        w_ptr_bit_nxt = r_ptr_bit;
        if (r_state == S_SWAP) begin
            if (w_last_bit) begin
                w_ptr_bit_nxt = 3'd0;
                w_ptr_row_nxt = w_last_row ? 6'd0 : r_ptr_row + 6'd1;
            end else begin
                w_ptr_bit_nxt = r_ptr_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_ptr_row    <= 6'd0;
            r_ptr_bit    <= 3'd0;
            r_wait_first <= 1'b0;
            r_blank_cnt  <= '0;
            r_fs_start   <= 1'b0;
            r_fs_bit_cnt <= 3'd0;
            r_fs_row_cnt <= 6'd0;
            r_addr       <= 6'd0;
            r_lat        <= 1'b0;
            r_oe_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_ptr_row    <= w_ptr_row_nxt;
            r_ptr_bit    <= w_ptr_bit_nxt;
            r_wait_first <= (r_state == S_KICK);

            if (w_state_nxt == S_BLANK && r_state != S_BLANK)
                r_blank_cnt <= BLANK_W'(BLANK_CYC - 1);
            else if (r_state == S_BLANK && r_blank_cnt != '0)
                r_blank_cnt <= r_blank_cnt - BLANK_W'(1);

            // Shifter plane/row stay put until the next kick
            r_fs_start <= (w_state_nxt == S_KICK);
            if (w_state_nxt == S_KICK) begin
                r_fs_row_cnt <= w_ptr_row_nxt;
                r_fs_bit_cnt <= w_ptr_bit_nxt;
            end

            if (r_state == S_WAIT && w_state_nxt == S_BLANK)
                r_addr <= r_fs_row_cnt;

            r_lat        <= (w_state_nxt == S_LATCH);
            r_oe_n       <= (w_timer_nxt == '0) || (w_state_nxt == S_BLANK) ||
                            (w_state_nxt == S_LATCH);
            r_frame_done <= (w_state_nxt == S_SWAP) && w_wrap;
        end
    end

    assign o_fs_start   = r_fs_start;
    assign o_fs_bit_cnt = r_fs_bit_cnt;
    assign o_fs_row_cnt = r_fs_row_cnt;
    assign o_addr       = r_addr;
    assign o_lat        = r_lat;
    assign o_oe_n       = r_oe_n;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: expected kicks and on-times are queued
// by the stimulus, a negedge monitor pops and compares as the DUT produces them.
module tb_hub75_scan_ctrl;

    localparam int ROWS      = 4;
    localparam int BITS      = 3;
    localparam int BASE_OE   = 4;
    localparam int BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fs_busy = 1'b0;
    logic       fs_start;
    logic [2:0] fs_bit_cnt;
    logic [5:0] fs_row_cnt;
    logic [5:0] addr;
    logic       lat;
    logic       oe_n;
    logic       frame_done;

    hub75_scan_ctrl #(
        .ROWS(ROWS), .BITS(BITS), .BASE_OE(BASE_OE), .BLANK_CYC(BLANK_CYC), .TIMER_W(16)
    ) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_enable(enable), .i_fs_busy(fs_busy),
        .o_fs_start(fs_start), .o_fs_bit_cnt(fs_bit_cnt), .o_fs_row_cnt(fs_row_cnt),
        .o_addr(addr), .o_lat(lat), .o_oe_n(oe_n), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_len = 6;
    int busy_left = 0;
    logic [8:0] q_kick[$];
    int q_oe[$];
    int n_kicks = 0;
    int n_fd = 0;
    int exp_row = 0;
    int last_row = -1;
    int last_bit = -1;
    bit armed = 0;
    int t0 = -1;
    int lat_cyc = -100;
    bit in_run = 0;
    int run_len = 0;
    bit prev_start = 0;
    logic [8:0] e;
    int exp_len;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Shifter model: busy for busy_len cycles after each start pulse
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) busy_left = 0;
            else begin
                if (busy_left > 0) busy_left--;
                if (fs_start) busy_left = busy_len;
            end
            fs_busy = (busy_left > 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            in_run = 0; run_len = 0; armed = 0; t0 = -1; prev_start = 0;
        end else begin
            if (fs_start) begin
                chk("start_width", int'(prev_start), 0);
                if (q_kick.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL kick_unexpected: got row %0d bit %0d, expected no kick",
                             fs_row_cnt, fs_bit_cnt);
                end else begin
                    e = q_kick.pop_front();
                    chk("kick_row", int'(fs_row_cnt), int'(e[8:3]));
                    chk("kick_bit", int'(fs_bit_cnt), int'(e[2:0]));
                    exp_row = int'(e[8:3]);
                    last_row = int'(e[8:3]);
                    last_bit = int'(e[2:0]);
                end
                n_kicks++;
                armed = 1;
                t0 = -1;
            end else if (armed && t0 < 0 && !fs_busy && oe_n) begin
                t0 = cyc;
            end
            if (lat) begin
                if (t0 < 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL lat_early: got lat at cycle %0d, expected after shift done and timer out", cyc);
                end else begin
                    chk("lat_gap", cyc - t0, BLANK_CYC + 1);
                end
                chk("lat_addr", int'(addr), exp_row);
                chk("lat_oe_n", int'(oe_n), 1);
                armed = 0;
                t0 = -1;
                lat_cyc = cyc;
            end
            if (frame_done) begin
                n_fd++;
                chk("fd_after_lat", cyc - lat_cyc, 1);
                chk("fd_last_plane", last_row * 8 + last_bit, (ROWS - 1) * 8 + BITS - 1);
            end
            if (!oe_n) begin
                run_len++;
                in_run = 1;
            end else if (in_run) begin
                if (q_oe.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL oe_unexpected: got run of %0d, expected none", run_len);
                end else begin
                    exp_len = q_oe.pop_front();
                    chk("oe_len", run_len, exp_len);
                end
                in_run = 0;
                run_len = 0;
            end
            prev_start = fs_start;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_plane(input int r, input int b, input bit with_oe);
        q_kick.push_back({6'(r), 3'(b)});
        if (with_oe) q_oe.push_back(BASE_OE << b);
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < BITS; b++)
                push_plane(r, b, 1'b1);
    endtask

    task automatic wait_kicks(input int n, input int budget);
        int k = 0;
        while (n_kicks < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("kicks_reached", n_kicks, n);
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (n_fd < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("frames_reached", n_fd, n);
    endtask

    task automatic check_idle_state(input string name);
        chk({name, "_start"}, int'(fs_start), 0);
        chk({name, "_bit"},   int'(fs_bit_cnt), 0);
        chk({name, "_row"},   int'(fs_row_cnt), 0);
        chk({name, "_addr"},  int'(addr), 0);
        chk({name, "_lat"},   int'(lat), 0);
        chk({name, "_oe_n"},  int'(oe_n), 1);
        chk({name, "_fd"},    int'(frame_done), 0);
    endtask

    task automatic end_of_run(input int fd_exp);
        wait_fd(fd_exp, 3000);
        tick(60);
        chk("q_kick_empty", q_kick.size(), 0);
        chk("q_oe_empty", q_oe.size(), 0);
        chk("fd_count", n_fd, fd_exp);
        chk("idle_oe_n", int'(oe_n), 1);
    endtask

    initial begin
        // Reset held, then idle with enable low
        tick(5);
        check_idle_state("rst_held");
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("idle_vec", int'({fs_start, fs_bit_cnt, fs_row_cnt, addr, lat, oe_n, frame_done}),
                int'({1'b0, 3'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0}));
        end

        // Full frame, enable dropped during row 1
        push_frame();
        enable = 1'b1;
        wait_kicks(4, 200);
        enable = 1'b0;
        end_of_run(1);

        // Long shifter busy: on-times run out before the shift completes
        busy_len = 40;
        push_frame();
        enable = 1'b1;
        wait_kicks(13, 200);
        enable = 1'b0;
        end_of_run(2);

        // Reset during plane 2 on-time of row 0
        busy_len = 6;
        push_plane(0, 0, 1'b1);
        push_plane(0, 1, 1'b1);
        push_plane(0, 2, 1'b0);
        push_plane(1, 0, 1'b0);
        enable = 1'b1;
        wait_kicks(28, 400);
        tick(5);
        chk("plane2_oe_low", int'(oe_n), 0);
        chk("plane2_row_cnt", int'(fs_row_cnt), 1);
        rst = 1'b1;
        enable = 1'b0;
        tick(1);
        check_idle_state("mid_rst");
        chk("rst_q_kick_empty", q_kick.size(), 0);
        chk("rst_q_oe_empty", q_oe.size(), 0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Restart from (0,0)
        push_frame();
        enable = 1'b1;
        wait_kicks(29, 50);
        enable = 1'b0;
        end_of_run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
